// File: rtl/core_pkg.sv
// Shared types for the core memory-port arbiter.
package core_pkg;

    localparam int unsigned ARB_NUM_M = 2;

    typedef enum logic {
        ARB_M0 = 1'b0,
        ARB_M1 = 1'b1
    } arb_id_t;

    // Round-robin partner of a master id.
    function automatic arb_id_t arb_other(input arb_id_t id);
        return (id == ARB_M0) ? ARB_M1 : ARB_M0;
    endfunction

endpackage

// File: rtl/core_bus_arb_idfifo.sv
// Outstanding-read id FIFO: remembers which master owns each read in flight.
module core_bus_arb_idfifo
    import core_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic    clk,
    input  logic    rest,
    input  logic    push,
    input  arb_id_t push_id,
    input  logic    pop,
    output arb_id_t head_id,
    output logic    full,
    output logic    empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    arb_id_t         mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head_id = mem_q[rd_ptr_q];

    // Storage, pointers (wrap naturally, DEPTH is a power of 2) and occupancy.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= ARB_M0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_id;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/core_bus_arb.sv
// Two-master Avalon-MM arbiter with round-robin grant and in-order read routing.
module core_bus_arb
    import core_pkg::*;
#(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic            clk,
    input  logic            rest,

    input  logic [AW-1:0]   m0_address,
    input  logic            m0_read,
    input  logic            m0_write,
    input  logic [DW-1:0]   m0_writedata,
    input  logic [DW/8-1:0] m0_byteenable,
    output logic [DW-1:0]   m0_readdata,
    output logic            m0_readdatavalid,
    output logic            m0_waitrequest,

    input  logic [AW-1:0]   m1_address,
    input  logic            m1_read,
    input  logic            m1_write,
    input  logic [DW-1:0]   m1_writedata,
    input  logic [DW/8-1:0] m1_byteenable,
    output logic [DW-1:0]   m1_readdata,
    output logic            m1_readdatavalid,
    output logic            m1_waitrequest,

    output logic [AW-1:0]   s_address,
    output logic            s_read,
    output logic            s_write,
    output logic [DW-1:0]   s_writedata,
    output logic [DW/8-1:0] s_byteenable,
    input  logic [DW-1:0]   s_readdata,
    input  logic            s_readdatavalid,
    input  logic            s_waitrequest,

    output logic            err_unexp_rsp
);

    logic    lock_q,    lock_d;
    arb_id_t lock_id_q, lock_id_d;
    arb_id_t last_q,    last_d;
    logic    err_q,     err_d;

    logic    req0, req1;
    logic    gnt_vld_c;
    arb_id_t gnt_c;
    logic    sel1;
    logic    gnt_rd, gnt_wr;
    logic    accept, stall;
    logic    push, pop;
    logic    fifo_full, fifo_empty;
    arb_id_t head_id;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Grant selection: locked master first, else round-robin; nothing while in reset.
    always_comb begin
        gnt_vld_c = 1'b0;
        gnt_c     = ARB_M0;
        if (lock_q) begin
            gnt_vld_c = 1'b1;
            gnt_c     = lock_id_q;
        end else if (req0 && req1) begin
            gnt_vld_c = 1'b1;
            gnt_c     = arb_other(last_q);
        end else if (req0) begin
            gnt_vld_c = 1'b1;
            gnt_c     = ARB_M0;
        end else if (req1) begin
            gnt_vld_c = 1'b1;
            gnt_c     = ARB_M1;
        end
        if (!rest) begin
            gnt_vld_c = 1'b0;
        end
    end

    assign sel1   = (gnt_c == ARB_M1);
    assign gnt_rd = sel1 ? m1_read  : m0_read;
    assign gnt_wr = sel1 ? m1_write : m0_write;

    assign s_address    = sel1 ? m1_address    : m0_address;
    assign s_writedata  = sel1 ? m1_writedata  : m0_writedata;
    assign s_byteenable = sel1 ? m1_byteenable : m0_byteenable;
    assign s_read       = gnt_vld_c & gnt_rd & ~fifo_full;
    assign s_write      = gnt_vld_c & gnt_wr;

    assign accept = (s_read | s_write) & ~s_waitrequest;
    assign stall  = (s_read | s_write) & s_waitrequest;
    assign push   = accept & s_read;
    assign pop    = rest & s_readdatavalid & ~fifo_empty;

    assign m0_waitrequest = ~(gnt_vld_c & ~sel1) | s_waitrequest | (m0_read & fifo_full);
    assign m1_waitrequest = ~(gnt_vld_c &  sel1) | s_waitrequest | (m1_read & fifo_full);

    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = pop & (head_id == ARB_M0);
    assign m1_readdatavalid = pop & (head_id == ARB_M1);
    assign err_unexp_rsp    = err_q;

    // Next values for lock, round-robin pointer and the sticky error flag.
    always_comb begin
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        last_d    = last_q;
        err_d     = err_q | (s_readdatavalid & fifo_empty);
        if (accept) begin
            last_d = gnt_c;
            lock_d = 1'b0;
        end else if (stall) begin
            lock_d    = 1'b1;
            lock_id_d = gnt_c;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            lock_q    <= 1'b0;
            lock_id_q <= ARB_M0;
            last_q    <= ARB_M1;
            err_q     <= 1'b0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            last_q    <= last_d;
            err_q     <= err_d;
        end
    end

    core_bus_arb_idfifo #(
        .DEPTH (MAX_OUTST)
    ) u_idfifo (
        .clk     (clk),
        .rest    (rest),
        .push    (push),
        .push_id (gnt_c),
        .pop     (pop),
        .head_id (head_id),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule
